// File: rtl/irs_block_readout_v4_if.sv
// rtl/irs_block_readout_v4_if.sv - request and word-stream bundle for the IRS block readout
interface irs_block_readout_v4_if #(
    parameter int ADDR_W = 9,
    parameter int NBLK_W = 4,
    parameter int NCH    = 8
);
    logic [ADDR_W-1:0] raddr_i;
    logic [NBLK_W-1:0] nblk_i;
    logic [NCH-1:0]    ch_mask_i;
    logic              raddr_stb_i;
    logic              raddr_ack_o;
    logic [15:0]       dat_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;

    modport slave (
        input  raddr_i, nblk_i, ch_mask_i, raddr_stb_i, ready_i,
        output raddr_ack_o, dat_o, valid_o, last_o
    );

    modport master (
        output raddr_i, nblk_i, ch_mask_i, raddr_stb_i, ready_i,
        input  raddr_ack_o, dat_o, valid_o, last_o
    );
endinterface

// File: rtl/irs_block_readout_v4.sv
// rtl/irs_block_readout_v4.sv - multi-block IRS digitise and scan sequencer with valid/ready word stream
module irs_block_readout_v4 #(
    parameter int STACK_NUMBER = 0,
    parameter int NCH          = 8,
    parameter int NSMP         = 64,
    parameter int ADDR_W       = 9,
    parameter int DAT_W        = 12,
    parameter int NBLK_W       = 4,
    parameter int ADDR_SETTLE  = 4,
    parameter int CLR_CYCLES   = 4,
    parameter int RAMP_CYCLES  = 512,
    parameter int SMP_SETTLE   = 2,
    localparam int CH_W  = (NCH > 1)  ? $clog2(NCH)  : 1,
    localparam int SMP_W = (NSMP > 1) ? $clog2(NSMP) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    irs_block_readout_v4_if.slave bus,
    input  logic [5:0]        station_i,
    input  logic              test_mode_i,
    output logic [ADDR_W-1:0] irs_rd_o,
    output logic              irs_rden_o,
    output logic              irs_clr_o,
    output logic              irs_start_o,
    output logic              irs_ramp_o,
    output logic [SMP_W-1:0]  irs_smp_o,
    output logic [CH_W-1:0]   irs_ch_o,
    output logic              irs_smpall_o,
    input  logic [DAT_W-1:0]  irs_dat_i,
    output logic              busy_o,
    output logic              err_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CLEAR, S_RAMP, S_HEADER, S_ADDRW, S_SCAN, S_NEXT
    } state_t;

    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(NSMP - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_q, rd_d;
    logic [NBLK_W-1:0] rem_q, rem_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [SMP_W-1:0]  smp_q, smp_d;
    logic [CH_W-1:0]   ch_q, ch_d, first_ch, next_ch;
    logic [15:0]       dat_q, dat_d;
    logic              ack_q, ack_d, rden_q, rden_d, clr_q, clr_d, start_q, start_d;
    logic              ramp_q, ramp_d, smpall_q, smpall_d, valid_q, valid_d;
    logic              last_q, last_d, busy_q, busy_d, err_q, err_d;
    logic              has_next, all_masked, hs;

    // Descending scan so the lowest qualifying channel is the one left assigned.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!mask_q[i]) begin
                first_ch = CH_W'(i);
                if (i > int'(ch_q)) begin
                    next_ch  = CH_W'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    assign all_masked = &mask_q;
    assign hs         = valid_q && bus.ready_i;

    always_comb begin
        state_d  = state_q;  cnt_d   = cnt_q;   addr_d  = addr_q;  rem_d    = rem_q;
        mask_d   = mask_q;   rd_d    = rd_q;    smp_d   = smp_q;   ch_d     = ch_q;
        dat_d    = dat_q;    ack_d   = 1'b0;    rden_d  = rden_q;  clr_d    = clr_q;
        start_d  = start_q;  ramp_d  = ramp_q;  smpall_d = smpall_q;
        valid_d  = valid_q;  last_d  = last_q;  busy_d  = busy_q;  err_d    = err_q;
        if (bus.raddr_stb_i && state_q != S_IDLE) err_d = 1'b1;
        case (state_q)
            S_IDLE: if (bus.raddr_stb_i) begin
                addr_d  = bus.raddr_i;  rem_d = bus.nblk_i;  mask_d = bus.ch_mask_i;
                rd_d    = bus.raddr_i;  ack_d = 1'b1;  busy_d = 1'b1;  rden_d = 1'b1;
                cnt_d   = '0;
                state_d = S_ADDR;
            end
            S_ADDR: if (cnt_q == 16'(ADDR_SETTLE - 1)) begin
                cnt_d = '0;  clr_d = 1'b1;  state_d = S_CLEAR;
            end else cnt_d = cnt_q + 16'd1;
            S_CLEAR: if (cnt_q == 16'(CLR_CYCLES - 1)) begin
                cnt_d = '0;  clr_d = 1'b0;  start_d = 1'b1;  ramp_d = 1'b1;  state_d = S_RAMP;
            end else cnt_d = cnt_q + 16'd1;
            S_RAMP: if (cnt_q == 16'(RAMP_CYCLES - 1)) begin
                cnt_d   = '0;  start_d = 1'b0;  ramp_d = 1'b0;  rden_d = 1'b0;
                valid_d = 1'b1;  last_d = 1'b0;
                dat_d   = {station_i, 2'(STACK_NUMBER), 8'(~mask_q)};
                state_d = S_HEADER;
            end else cnt_d = cnt_q + 16'd1;
            S_HEADER: if (hs) begin
                dat_d   = 16'(addr_q);
                last_d  = all_masked && (rem_q == '0);
                state_d = S_ADDRW;
            end
            S_ADDRW: if (hs) begin
                valid_d = 1'b0;  last_d = 1'b0;
                if (all_masked) state_d = S_NEXT;
                else begin
                    ch_d = first_ch;  smp_d = '0;  smpall_d = 1'b1;  cnt_d = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!valid_q) begin
                    if (cnt_q == 16'(SMP_SETTLE - 1)) begin
                        valid_d = 1'b1;
                        dat_d   = test_mode_i ? 16'({2'(STACK_NUMBER), ch_q, smp_q})
                                              : 16'(irs_dat_i);
                        last_d  = (rem_q == '0) && (smp_q == SMP_LAST) && !has_next;
                    end else cnt_d = cnt_q + 16'd1;
                end else if (bus.ready_i) begin
                    // Select for the next word goes out on the same edge as the handshake.
                    valid_d = 1'b0;  last_d = 1'b0;  cnt_d = '0;
                    if (smp_q != SMP_LAST) smp_d = smp_q + 1'b1;
                    else if (has_next) begin
                        ch_d = next_ch;  smp_d = '0;
                    end else begin
                        smpall_d = 1'b0;  state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                addr_d = addr_q + 1'b1;
                if (rem_q == '0) begin
                    busy_d = 1'b0;  state_d = S_IDLE;
                end else begin
                    rem_d  = rem_q - 1'b1;  rd_d = addr_q + 1'b1;
                    rden_d = 1'b1;  cnt_d = '0;  state_d = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;  cnt_q  <= '0;  addr_q  <= '0;  rem_q   <= '0;  mask_q  <= '0;
            rd_q    <= '0;      smp_q  <= '0;  ch_q    <= '0;  dat_q   <= '0;  ack_q   <= 1'b0;
            rden_q  <= 1'b0;    clr_q  <= 1'b0; start_q <= 1'b0; ramp_q <= 1'b0; smpall_q <= 1'b0;
            valid_q <= 1'b0;    last_q <= 1'b0; busy_q  <= 1'b0; err_q  <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q  <= cnt_d;  addr_q  <= addr_d;  rem_q  <= rem_d;  mask_q  <= mask_d;
            rd_q    <= rd_d;    smp_q  <= smp_d;  ch_q    <= ch_d;    dat_q  <= dat_d;  ack_q   <= ack_d;
            rden_q  <= rden_d;  clr_q  <= clr_d;  start_q <= start_d; ramp_q <= ramp_d; smpall_q <= smpall_d;
            valid_q <= valid_d; last_q <= last_d; busy_q  <= busy_d;  err_q  <= err_d;
        end
    end

    assign bus.raddr_ack_o = ack_q;
    assign bus.dat_o       = dat_q;
    assign bus.valid_o     = valid_q;
    assign bus.last_o      = last_q;
    assign irs_rd_o        = rd_q;
    assign irs_rden_o      = rden_q;
    assign irs_clr_o       = clr_q;
    assign irs_start_o     = start_q;
    assign irs_ramp_o      = ramp_q;
    assign irs_smp_o       = smp_q;
    assign irs_ch_o        = ch_q;
    assign irs_smpall_o    = smpall_q;
    assign busy_o          = busy_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_irs_block_readout_v4.sv
// tb/tb_irs_block_readout_v4.sv - self-checking bench for irs_block_readout_v4
module tb_irs_block_readout_v4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  station = 6'h15;
    logic        test_mode = 1'b1;
    logic [8:0]  irs_rd;
    logic        irs_rden, irs_clr, irs_start, irs_ramp, irs_smpall, busy, err;
    logic [5:0]  irs_smp;
    logic [2:0]  irs_ch;
    logic [11:0] irs_dat;

    irs_block_readout_v4_if #(.ADDR_W(9), .NBLK_W(4), .NCH(8)) bus_if ();

    irs_block_readout_v4 dut (
        .clk_i(clk), .rst_i(rst), .bus(bus_if.slave),
        .station_i(station), .test_mode_i(test_mode),
        .irs_rd_o(irs_rd), .irs_rden_o(irs_rden), .irs_clr_o(irs_clr),
        .irs_start_o(irs_start), .irs_ramp_o(irs_ramp), .irs_smp_o(irs_smp),
        .irs_ch_o(irs_ch), .irs_smpall_o(irs_smpall), .irs_dat_i(irs_dat),
        .busy_o(busy), .err_o(err)
    );

    // IRS analogue model: each (channel, sample) cell holds a distinct value.
    assign irs_dat = 12'(irs_ch * 12'd97 + irs_smp * 12'd13 + 12'd5);

    int total = 0;
    int bad = 0;
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    int ack_cnt = 0, smpall_rise = 0, clr_cyc = 0, ramp_cyc = 0, addr_cyc = 0, settle_cyc = 0, viol = 0;
    logic        pv = 1'b0, pr = 1'b0, psa = 1'b0;
    logic [15:0] pd = '0;
    logic [5:0]  ps = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.valid_o && bus_if.ready_i) got_q.push_back({bus_if.last_o, bus_if.dat_o});
            if (bus_if.raddr_ack_o) ack_cnt <= ack_cnt + 1;
            if (irs_smpall && !psa) smpall_rise <= smpall_rise + 1;
            if (irs_clr && irs_rden) clr_cyc <= clr_cyc + 1;
            if (irs_ramp && irs_start && irs_rden) ramp_cyc <= ramp_cyc + 1;
            if (irs_rden && !irs_clr && !irs_ramp) addr_cyc <= addr_cyc + 1;
            if (irs_smpall && !bus_if.valid_o) settle_cyc <= settle_cyc + 1;
            if (pv && !pr && (!bus_if.valid_o || bus_if.dat_o !== pd || irs_smp !== ps)) viol <= viol + 1;
        end
        pv  <= bus_if.valid_o && !rst;
        pr  <= bus_if.ready_i;
        pd  <= bus_if.dat_o;
        ps  <= irs_smp;
        psa <= irs_smpall;
    end

    // Reference: the word list a request must produce, built from the block/channel/sample rules.
    task automatic build_exp(input logic [5:0] st, input logic [7:0] mask, input logic [8:0] ra,
                             input int nb, input logic tm);
        logic [7:0] nm;
        nm = ~mask;
        exp_q.delete();
        for (int b = 0; b <= nb; b++) begin
            exp_q.push_back({1'b0, st, 2'b00, nm});
            exp_q.push_back({1'b0, 16'((int'(ra) + b) % 512)});
            for (int c = 0; c < 8; c++)
                if (!mask[c])
                    for (int s = 0; s < 64; s++)
                        exp_q.push_back(tm ? {1'b0, 16'(c * 64 + s)}
                                           : {1'b0, 16'((c * 97 + s * 13 + 5) % 4096)});
        end
        exp_q[exp_q.size() - 1][16] = 1'b1;
    endtask

    function automatic int first_diff(input int n0);
        for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++)
            if (got_q[n0 + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic issue(input logic [8:0] ra, input logic [3:0] nb, input logic [7:0] mask);
        @(posedge clk); #1;
        bus_if.raddr_i = ra;  bus_if.nblk_i = nb;  bus_if.ch_mask_i = mask;
        bus_if.raddr_stb_i = 1'b1;
        @(posedge clk); #1;
        bus_if.raddr_stb_i = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, output bit to);
        to = 1'b1;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk); #1;
            if (rnd) bus_if.ready_i = ($urandom % 4) != 0;
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        bus_if.ready_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_ramp(output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (irs_ramp) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({bus_if.raddr_ack_o, irs_rd, irs_rden, irs_clr, irs_start, irs_ramp, irs_smp, irs_ch,
             irs_smpall, bus_if.dat_o, bus_if.valid_o, bus_if.last_o, busy, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b valid=%b dat=%h err=%b rd=%h required all zero",
                     busy, bus_if.valid_o, bus_if.dat_o, err, irs_rd);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || bus_if.valid_o !== 1'b0 || irs_rden !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b valid=%b rden=%b required 0", busy, bus_if.valid_o, irs_rden);
        end
    endtask

    task automatic test_basic(input string nm);
        int n0, a0, s0, d;
        bit to;
        n0 = got_q.size();  a0 = ack_cnt;  s0 = settle_cyc;
        build_exp(6'h15, 8'hFE, 9'h005, 0, 1'b1);
        issue(9'h005, 4'd0, 8'hFE);
        total++;
        if (bus_if.raddr_ack_o !== 1'b1 || busy !== 1'b1 || irs_rd !== 9'h005) begin
            bad++;
            $display("FAIL %s_ack ack=%b busy=%b rd=%h required 1 1 005", nm, bus_if.raddr_ack_o, busy, irs_rd);
        end
        @(posedge clk); #1;
        total++;
        if (bus_if.raddr_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack_pulse ack=%b required 0", nm, bus_if.raddr_ack_o);
        end
        wait_done(1'b0, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL %s_timeout busy=%b required 0", nm, busy);
        end
        total++;
        if (got_q.size() - n0 !== 66) begin
            bad++;
            $display("FAIL %s_count got=%0d required 66", nm, got_q.size() - n0);
        end
        d = first_diff(n0);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL %s_words idx=%0d got=%h required %h", nm, d, got_q[n0 + d], exp_q[d]);
        end
        total++;
        if (ack_cnt - a0 !== 1 || settle_cyc - s0 !== 128) begin
            bad++;
            $display("FAIL %s_acks_settle acks=%0d settle=%0d required 1 128", nm, ack_cnt - a0, settle_cyc - s0);
        end
    endtask

    task automatic test_wrap();
        int n0, d;
        bit to;
        n0 = got_q.size();
        build_exp(6'h15, 8'h7F, 9'h1FF, 1, 1'b1);
        issue(9'h1FF, 4'd1, 8'h7F);
        wait_done(1'b0, to);
        total++;
        if (to || got_q.size() - n0 !== 132) begin
            bad++;
            $display("FAIL wrap_count timeout=%b got=%0d required 132", to, got_q.size() - n0);
        end
        d = first_diff(n0);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL wrap_words idx=%0d got=%h required %h", d, got_q[n0 + d], exp_q[d]);
        end
    endtask

    task automatic test_backpressure();
        int n0, v0, d;
        bit to, seen;
        logic [15:0] held;
        n0 = got_q.size();  v0 = viol;
        build_exp(6'h15, 8'hFE, 9'h005, 0, 1'b1);
        issue(9'h005, 4'd0, 8'hFE);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (irs_smpall && irs_smp == 6'd10 && !bus_if.valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        bus_if.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        held = bus_if.dat_o;
        total++;
        if (!seen || bus_if.valid_o !== 1'b1 || held !== 16'd10) begin
            bad++;
            $display("FAIL bp_stall_word seen=%b valid=%b dat=%h required 1 1 000a", seen, bus_if.valid_o, held);
        end
        repeat (47) @(posedge clk);
        #1;
        total++;
        if (bus_if.valid_o !== 1'b1 || bus_if.dat_o !== held || irs_smp !== 6'd10) begin
            bad++;
            $display("FAIL bp_hold valid=%b dat=%h smp=%0d required 1 %h 10", bus_if.valid_o, bus_if.dat_o, irs_smp, held);
        end
        bus_if.ready_i = 1'b1;
        wait_done(1'b0, to);
        d = first_diff(n0);
        total++;
        if (to || got_q.size() - n0 !== 66 || d != -1 || viol !== v0) begin
            bad++;
            $display("FAIL bp_stream timeout=%b count=%0d diff_idx=%0d viol=%0d required 0 66 -1 %0d",
                     to, got_q.size() - n0, d, viol, v0);
        end
    endtask

    task automatic test_err();
        int n0, a0;
        bit to, tr;
        n0 = got_q.size();  a0 = ack_cnt;
        issue(9'h005, 4'd0, 8'hFE);
        wait_ramp(tr);
        bus_if.raddr_i = 9'h100;
        bus_if.raddr_stb_i = 1'b1;
        @(posedge clk); #1;
        bus_if.raddr_stb_i = 1'b0;
        total++;
        if (tr || err !== 1'b1) begin
            bad++;
            $display("FAIL err_set ramp_timeout=%b err=%b required 0 1", tr, err);
        end
        wait_done(1'b0, to);
        total++;
        if (to || ack_cnt - a0 !== 1 || got_q.size() - n0 !== 66 || err !== 1'b1) begin
            bad++;
            $display("FAIL err_after timeout=%b acks=%0d words=%0d err=%b required 0 1 66 1",
                     to, ack_cnt - a0, got_q.size() - n0, err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_cleared err=%b required 0", err);
        end
    endtask

    task automatic test_all_masked();
        int n0, m0, c0, r0, ad0, d;
        bit to;
        n0 = got_q.size();  m0 = smpall_rise;  c0 = clr_cyc;  r0 = ramp_cyc;  ad0 = addr_cyc;
        build_exp(6'h15, 8'hFF, 9'h0A3, 2, 1'b1);
        issue(9'h0A3, 4'd2, 8'hFF);
        wait_done(1'b0, to);
        d = first_diff(n0);
        total++;
        if (to || got_q.size() - n0 !== 6 || d != -1) begin
            bad++;
            $display("FAIL masked_words timeout=%b count=%0d diff_idx=%0d required 0 6 -1", to, got_q.size() - n0, d);
        end
        total++;
        if (smpall_rise - m0 !== 0) begin
            bad++;
            $display("FAIL masked_smpall pulses=%0d required 0", smpall_rise - m0);
        end
        total++;
        if (clr_cyc - c0 !== 12 || ramp_cyc - r0 !== 1536 || addr_cyc - ad0 !== 12) begin
            bad++;
            $display("FAIL masked_phases clr=%0d ramp=%0d addr=%0d required 12 1536 12",
                     clr_cyc - c0, ramp_cyc - r0, addr_cyc - ad0);
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit tr;
        issue(9'h033, 4'd3, 8'h00);
        wait_ramp(tr);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (tr || {bus_if.raddr_ack_o, irs_rd, irs_rden, irs_clr, irs_start, irs_ramp, irs_smp, irs_ch,
                   irs_smpall, bus_if.dat_o, bus_if.valid_o, bus_if.last_o, busy, err} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs ramp_timeout=%b busy=%b ramp=%b rden=%b rd=%h required 0 all zero",
                     tr, busy, irs_ramp, irs_rden, irs_rd);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        test_basic("after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [7:0] mask;
            logic [8:0] ra;
            logic [3:0] nb;
            logic [5:0] st;
            int n0, d;
            bit to;
            mask = (it == 3) ? 8'hFF : 8'($urandom);
            ra   = 9'($urandom);
            nb   = 4'($urandom_range(0, 1));
            st   = 6'($urandom);
            station   = st;
            test_mode = 1'($urandom);
            n0 = got_q.size();
            build_exp(st, mask, ra, int'(nb), test_mode);
            issue(ra, nb, mask);
            wait_done(1'b1, to);
            d = first_diff(n0);
            total++;
            if (to || got_q.size() - n0 !== exp_q.size() || d != -1) begin
                bad++;
                $display("FAIL random_%0d timeout=%b count=%0d diff_idx=%0d required 0 %0d -1",
                         it, to, got_q.size() - n0, d, exp_q.size());
            end
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL stream_stability violations=%0d required 0", viol);
        end
    endtask

    initial begin
        bus_if.raddr_i = '0;  bus_if.nblk_i = '0;  bus_if.ch_mask_i = '0;
        bus_if.raddr_stb_i = 1'b0;  bus_if.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic("basic");
        test_wrap();
        test_backpressure();
        test_err();
        test_all_masked();
        test_reset_mid_ramp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
